instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the control decoder: builds 32-bit MIPS instruction words from individual fields.
- Accepts one instruction per valid/ready handshake and checks that its opcode is one the processor supports.
- Writes legal words into instruction memory at consecutive word addresses, using the bench/boot-loader write port.
- Used for self-checking program load before the core is released from reset.

Parameters:
- DEPTH, 64, maximum number of words written per load session.
- BASE_ADDR, 32'h0040_0000, byte address of the first written word.
- CNT_WIDTH, 7, width of the word counter; must satisfy 2^CNT_WIDTH > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a load session.
- in_valid_i  in  1  instruction fields are valid.
- in_ready_o  out  1  block can accept a field set this cycle.
- last_i  in  1  marks the final instruction of the session; qualified by handshake.
- opcode_i  in  6  opcode field.
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register and shift fields.
- funct_i  in  6  R-type function field.
- imm_i  in  16  immediate field.
- wr_en_o  out  1  instruction-memory write strobe.
- wr_addr_o  out  32  byte address of the write.
- wr_data_o  out  32  encoded instruction word.
- count_o  out  CNT_WIDTH  number of words written in this session.
- busy_o  out  1  high in the LOAD state.
- done_o  out  1  session finished; held until the next start.
- full_o  out  1  session ended because DEPTH words were written.
- err_o  out  1  sticky flag: at least one illegal opcode was accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs become 0; count_o becomes 0.
  - Any pending write is dropped.
  - This applies mid-session as well.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start_i; count is cleared and err is cleared.
  - LOAD -> DONE one cycle after the handshake carrying last_i=1, or when count reaches DEPTH.
  - DONE -> LOAD on start_i; count and err are cleared.
  - start_i is ignored while in LOAD.
- in_ready_o = (state==LOAD) && (count + pending_write < DEPTH) && !last_seen.
- A handshake occurs when in_valid_i && in_ready_o.
- Legal opcodes: 0x00, 0x08, 0x0D, 0x0C, 0x0F, 0x2B, 0x23.
- Encoding:
  - R-type (0x00): {op, rs, rt, rd, shamt, funct}.
  - LUI: {op, 5'b0, rt, imm}; rs_i is ignored.
  - Other I-type: {op, rs, rt, imm}.
- Latency: a handshake on cycle N produces wr_en_o=1 on cycle N+1, with registered wr_addr_o and wr_data_o.
- Addressing: wr_addr_o = BASE_ADDR + 4*count, where count is the value before the increment; count increments in the same cycle as the write.
- Illegal opcode:
  - err_o is set in the cycle after the handshake.
  - No write occurs and count is unchanged.
  - The handshake still completes, including the effect of last_i.
- Full: when count reaches DEPTH, full_o=1, done_o=1, in_ready_o=0.
- If the last legal write and last_i coincide with reaching DEPTH, both full_o and done_o are asserted.
- An illegal last_i handshake completes the session with no write.
- wr_en_o is a single-cycle pulse. wr_addr_o and wr_data_o hold their values between writes.
- Throughput is one instruction per cycle while ready.

Optional Feature:
- Macro: ENCODER_ILLEGAL_NOP_EN.
- Defined: an illegal opcode writes 32'h0000_0000 (sll $0,$0,0) at the current address, count increments, and err_o is still set.
- Undefined: an illegal opcode is dropped as described in Behaviour.

Decomposition:
- Package mips_isa_pkg holds:
  - Opcode constants: R_TYPE=6'h0, ADDI=6'h8, ORI=6'hd, ANDI=6'hc, LUI=6'hf, SW=6'h2b, LW=6'h23.
  - Field width constants.
  - FSM state encoding.
- Combinational sub-module instr_field_packer: takes the fields and returns {word[31:0], legal}. It is reusable by the bench's reference model.

Test Plan:
- ADDI $t0,$zero,5 (op 8, rs 0, rt 8, imm 5) after start -> one cycle later wr_en_o=1, wr_addr_o=0x00400000, wr_data_o=0x20080005, count_o=1.
- Back-to-back handshakes:
  - ORI $t1,$t0,0xFF -> 0x350900FF at 0x00400004.
  - ADD rs8 rt9 rd10 funct 0x20 -> 0x01095020 at 0x00400008.
  - LW rs29 rt11 imm4 with last_i=1 -> 0x8FAB0004 at 0x0040000C; done_o=1, count_o=4.
- LUI rt1 imm 0x1001 with rs_i=5 -> 0x3C011001.
- Illegal opcode 0x02 between two legal instructions:
  - err_o=1; the addresses of the legal writes are contiguous; count excludes the illegal entry.
  - With ENCODER_ILLEGAL_NOP_EN defined, a 0x00000000 word is written and the count includes it.
- DEPTH=4, stream 6 legal instructions with in_valid_i held high -> exactly 4 writes, in_ready_o=0 afterwards, full_o=1, done_o=1.
- Assert reset=0 for one cycle mid-session with a write pending -> no write the next cycle, all outputs 0, state IDLE; start_i then restarts at 0x00400000.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants, field widths and loader FSM encoding shared by the
// instruction encoder/loader and its field packer.
package mips_isa_pkg;

  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int WORD_W  = 32;

  localparam logic [OP_W-1:0] R_TYPE = 6'h00;
  localparam logic [OP_W-1:0] ADDI   = 6'h08;
  localparam logic [OP_W-1:0] ORI    = 6'h0d;
  localparam logic [OP_W-1:0] ANDI   = 6'h0c;
  localparam logic [OP_W-1:0] LUI    = 6'h0f;
  localparam logic [OP_W-1:0] SW     = 6'h2b;
  localparam logic [OP_W-1:0] LW     = 6'h23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      R_TYPE, ADDI, ORI, ANDI, LUI, SW, LW: is_legal_op = 1'b1;
      default:                              is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-input handshake, instruction-memory write port and session status
// of the instruction encoder/loader.
interface instr_encoder_loader_if #(
  parameter int CNT_WIDTH = 7
);
  import mips_isa_pkg::*;

  logic                 start_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 last_i;
  logic [OP_W-1:0]      opcode_i;
  logic [REG_W-1:0]     rs_i;
  logic [REG_W-1:0]     rt_i;
  logic [REG_W-1:0]     rd_i;
  logic [SHAMT_W-1:0]   shamt_i;
  logic [FUNCT_W-1:0]   funct_i;
  logic [IMM_W-1:0]     imm_i;
  logic                 wr_en_o;
  logic [31:0]          wr_addr_o;
  logic [WORD_W-1:0]    wr_data_o;
  logic [CNT_WIDTH-1:0] count_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 full_o;
  logic                 err_o;

  modport master (
    output start_i, in_valid_i, last_i, opcode_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i,
    input  in_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, busy_o, done_o, full_o, err_o
  );

  modport slave (
    input  start_i, in_valid_i, last_i, opcode_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i,
    output in_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, busy_o, done_o, full_o, err_o
  );

endinterface

// File: rtl/instr_field_packer.sv
// Combinational MIPS field packer: returns the encoded word and a legal flag;
// illegal opcodes encode as 32'h0000_0000 (sll $0,$0,0).
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  logic [OP_W-1:0]    i_opcode,
  input  logic [REG_W-1:0]   i_rs,
  input  logic [REG_W-1:0]   i_rt,
  input  logic [REG_W-1:0]   i_rd,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic [IMM_W-1:0]   i_imm,
  output logic [WORD_W-1:0]  o_word,
  output logic               o_legal
);

  // Format selection by opcode; LUI has no rs source so that field is zeroed.
  always_comb begin
    o_legal = is_legal_op(i_opcode);
    o_word  = 32'h0000_0000;
    if (o_legal) begin
      case (i_opcode)
        R_TYPE:  o_word = {i_opcode, i_rs, i_rt, i_rd, i_shamt, i_funct};
        LUI:     o_word = {i_opcode, 5'b00000, i_rt, i_imm};
        default: o_word = {i_opcode, i_rs, i_rt, i_imm};
      endcase
    end else begin
      o_word = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes MIPS field sets and writes legal words to consecutive instruction
// memory addresses. ENCODER_ILLEGAL_NOP_EN: illegal opcodes write a NOP instead of being dropped.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          CNT_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_encoder_loader_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] L_DEPTH    = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] L_LAST_IDX = CNT_WIDTH'(DEPTH - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_wr_en;
  logic [31:0]          r_wr_addr;
  logic [WORD_W-1:0]    r_wr_data;
  logic                 r_err;
  logic                 r_done;
  logic                 r_full;

  logic [WORD_W-1:0]    w_word;
  logic                 w_legal;
  logic                 w_ready;
  logic                 w_hs;
  logic                 w_do_write;
  logic                 w_cnt_hit;
  logic                 w_finish;
  logic                 w_clear;
  logic [31:0]          w_addr;

  instr_field_packer u_packer (
    .i_opcode (bus.opcode_i),
    .i_rs     (bus.rs_i),
    .i_rt     (bus.rt_i),
    .i_rd     (bus.rd_i),
    .i_shamt  (bus.shamt_i),
    .i_funct  (bus.funct_i),
    .i_imm    (bus.imm_i),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  // Count advances at the handshake edge, so no separate pending-write term is needed.
  assign w_ready = (r_state == ST_LOAD) && (r_count < L_DEPTH);
  assign w_hs    = bus.in_valid_i && w_ready;
`ifdef ENCODER_ILLEGAL_NOP_EN
  assign w_do_write = w_hs;
`else
  assign w_do_write = w_hs && w_legal;
`endif
  assign w_cnt_hit = w_do_write && (r_count == L_LAST_IDX);
  assign w_finish  = w_hs && (bus.last_i || w_cnt_hit);
  assign w_addr    = BASE_ADDR + 32'({r_count, 2'b00});

  // Next state: start opens a session from IDLE or DONE; last or full closes it.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          w_state_nxt = ST_LOAD;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = r_state;
          w_clear     = 1'b0;
        end
      end
      ST_LOAD: begin
        if (w_finish) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, write port and sticky session flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 32'h0000_0000;
      r_wr_data <= 32'h0000_0000;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_do_write;
      if (w_do_write) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_word;
      end
      if (w_clear) begin
        r_count <= '0;
        r_err   <= 1'b0;
        r_done  <= 1'b0;
        r_full  <= 1'b0;
      end else begin
        if (w_do_write)          r_count <= r_count + CNT_WIDTH'(1);
        if (w_hs && !w_legal)    r_err   <= 1'b1;
        if (w_finish)            r_done  <= 1'b1;
        if (w_cnt_hit)           r_full  <= 1'b1;
      end
    end
  end

  assign bus.in_ready_o = w_ready;
  assign bus.wr_en_o    = r_wr_en;
  assign bus.wr_addr_o  = r_wr_addr;
  assign bus.wr_data_o  = r_wr_data;
  assign bus.count_o    = r_count;
  assign bus.busy_o     = (r_state == ST_LOAD);
  assign bus.done_o     = r_done;
  assign bus.full_o     = r_full;
  assign bus.err_o      = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against a
// session-level reference model built from the encoding and session rules.
module tb_instr_encoder_loader;

  localparam int          DEPTH = 4;
  localparam int          CW    = 3;
  localparam logic [31:0] BASE  = 32'h0040_0000;
`ifdef ENCODER_ILLEGAL_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.CNT_WIDTH(CW)) u_if ();

  instr_encoder_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .CNT_WIDTH (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  bit          m_loading, m_wr_en, m_err, m_done, m_full;
  int          m_count;
  logic [31:0] m_addr, m_data;

  logic [5:0] legal_ops [7] = '{6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h2b, 6'h23};
  logic [5:0] bad_ops   [3] = '{6'h02, 6'h3f, 6'h04};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {legal, word} straight from the MIPS field layout
  function automatic logic [32:0] ref_encode(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                             input logic [5:0] fn, input logic [15:0] imm);
    logic [31:0] w;
    if (!(op inside {6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h2b, 6'h23})) return {1'b0, 32'h0};
    if (op == 6'h00)
      w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    else if (op == 6'h0f)
      w = (32'(op) << 26) | (32'(rt) << 16) | 32'(imm);
    else
      w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return {1'b1, w};
  endfunction

  task automatic check_outputs();
    check_val("wr_en",   32'(u_if.wr_en_o),    32'(m_wr_en));
    check_val("wr_addr", u_if.wr_addr_o,       m_addr);
    check_val("wr_data", u_if.wr_data_o,       m_data);
    check_val("count",   32'(u_if.count_o),    m_count);
    check_val("busy",    32'(u_if.busy_o),     32'(m_loading));
    check_val("done",    32'(u_if.done_o),     32'(m_done));
    check_val("full",    32'(u_if.full_o),     32'(m_full));
    check_val("err",     32'(u_if.err_o),      32'(m_err));
    check_val("ready",   32'(u_if.in_ready_o), 32'(m_loading && (m_count < DEPTH)));
  endtask

  task automatic step(input bit rst_v, input bit st, input bit v, input bit lst,
                      input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                      input logic [5:0] fn, input logic [15:0] imm);
    bit          hs;
    logic [32:0] enc;
    reset           = rst_v;
    u_if.start_i    = st;
    u_if.in_valid_i = v;
    u_if.last_i     = lst;
    u_if.opcode_i   = op;
    u_if.rs_i       = rs;
    u_if.rt_i       = rt;
    u_if.rd_i       = rd;
    u_if.shamt_i    = sh;
    u_if.funct_i    = fn;
    u_if.imm_i      = imm;
    hs      = v && m_loading && (m_count < DEPTH);
    m_wr_en = 1'b0;
    if (!rst_v) begin
      m_loading = 1'b0; m_err = 1'b0; m_done = 1'b0; m_full = 1'b0;
      m_count = 0; m_addr = 32'h0; m_data = 32'h0;
    end else if (hs) begin
      enc = ref_encode(op, rs, rt, rd, sh, fn, imm);
      if (enc[32] || NOP_EN) begin
        m_wr_en = 1'b1;
        m_addr  = BASE + 32'(4 * m_count);
        m_data  = enc[31:0];
        m_count++;
      end
      if (!enc[32]) m_err = 1'b1;
      if (lst || m_count == DEPTH) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
        m_full    = (m_count == DEPTH);
      end
    end else if (st && !m_loading) begin
      m_loading = 1'b1; m_count = 0; m_err = 1'b0; m_done = 1'b0; m_full = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (u_if.wr_en_o) n_writes++;
    check_outputs();
  endtask

  task automatic idle_step(input bit st);
    step(1'b1, st, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000);
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                      input logic [5:0] fn, input logic [15:0] imm, input bit lst);
    step(1'b1, 1'b0, 1'b1, lst, op, rs, rt, rd, sh, fn, imm);
  endtask

  initial begin
    int w0;
    logic [5:0] op;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005);

    // program load of four words ending on both last and full
    idle_step(1'b1);
    send(6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 1'b0);
    check_val("addi_data", u_if.wr_data_o, 32'h2008_0005);
    check_val("addi_addr", u_if.wr_addr_o, 32'h0040_0000);
    send(6'h0d, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 16'h00ff, 1'b0);
    check_val("ori_data", u_if.wr_data_o, 32'h3509_00ff);
    send(6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0000, 1'b0);
    check_val("add_data", u_if.wr_data_o, 32'h0109_5020);
    send(6'h23, 5'd29, 5'd11, 5'd0, 5'd0, 6'h00, 16'h0004, 1'b1);
    check_val("lw_data", u_if.wr_data_o, 32'h8fab_0004);
    check_val("lw_addr", u_if.wr_addr_o, 32'h0040_000c);
    check_val("lw_done", 32'(u_if.done_o), 32'd1);
    idle_step(1'b0);

    // LUI ignores rs; illegal opcode between two legal words
    idle_step(1'b1);
    send(6'h0f, 5'd5, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1001, 1'b0);
    check_val("lui_data", u_if.wr_data_o, 32'h3c01_1001);
    send(6'h02, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1234, 1'b0);
    check_val("illegal_err", 32'(u_if.err_o), 32'd1);
    send(6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 1'b1);
    check_val("post_illegal_addr", u_if.wr_addr_o, BASE + (NOP_EN ? 32'd8 : 32'd4));

    // six legal words streamed into a DEPTH-word session
    idle_step(1'b1);
    w0 = n_writes;
    for (int i = 0; i < 6; i++)
      send(legal_ops[$urandom_range(0, 6)], 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 6'($urandom), 16'($urandom), 1'b0);
    check_val("full_writes", n_writes - w0, 32'(DEPTH));
    check_val("full_flag", 32'(u_if.full_o), 32'd1);

    // reset with a write pending, then restart from the base address
    idle_step(1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005);
    idle_step(1'b1);
    send(6'h0c, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h00f0, 1'b0);
    check_val("restart_addr", u_if.wr_addr_o, 32'h0040_0000);

    for (int i = 0; i < 400; i++) begin
      int r;
      r  = $urandom_range(0, 99);
      op = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 6)] : bad_ops[$urandom_range(0, 2)];
      if (r < 3)
        step(1'b0, 1'b0, 1'b1, 1'b0, op, 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 6'($urandom), 16'($urandom));
      else if (r < 12)
        idle_step(1'b1);
      else
        step(1'b1, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
             op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
